// File: rtl/demo_out_arbiter_pkg.sv
// demo_arb_pkg: FSM state encoding and default sizing shared by the demo_out_arbiter slice.
// Optional pre-emption is enabled by defining DEMO_ARB_TIMEOUT_EN (see demo_arb_out).
package demo_arb_pkg;

  localparam int unsigned N_REQ    = 4;
  localparam int unsigned DW       = 4;
  localparam int unsigned MIN_HOLD = 2;
  localparam int unsigned MAX_HOLD = 15;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    HOLD = 2'd1,
    GAP  = 2'd2
  } state_t;

endpackage

// File: rtl/demo_out_arbiter_if.sv
// Requester/pin-group bundle of demo_out_arbiter: requests and data in, grant and pin data out.
// The slave modport is the arbiter side, the master modport is the requester side.
interface demo_out_arbiter_if #(
  parameter int unsigned N_REQ = demo_arb_pkg::N_REQ,
  parameter int unsigned DW    = demo_arb_pkg::DW
);

  logic [N_REQ-1:0]         REQ;
  logic [N_REQ*DW-1:0]      DATA;
  logic [N_REQ-1:0]         GNT;
  logic [DW-1:0]            O;
  logic [$clog2(N_REQ)-1:0] OWNER;
  logic                     BUSY;

  modport master (output REQ, DATA, input GNT, O, OWNER, BUSY);
  modport slave  (input REQ, DATA, output GNT, O, OWNER, BUSY);

endinterface

// File: rtl/demo_out_arbiter_arb_out.sv
// demo_arb_out: IDLE/HOLD/GAP grant FSM, hold counter and registered pin outputs.
// Define DEMO_ARB_TIMEOUT_EN to pre-empt an owner at MAX_HOLD-1 when others are waiting.
module demo_arb_out #(
  parameter  int unsigned N_REQ    = demo_arb_pkg::N_REQ,
  parameter  int unsigned DW       = demo_arb_pkg::DW,
  parameter  int unsigned MIN_HOLD = demo_arb_pkg::MIN_HOLD,
  parameter  int unsigned MAX_HOLD = demo_arb_pkg::MAX_HOLD,
  localparam int unsigned IW       = $clog2(N_REQ)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic [N_REQ-1:0]    REQ,
  input  logic [N_REQ*DW-1:0] DATA,
  output logic [N_REQ-1:0]    GNT,
  output logic [DW-1:0]       O,
  output logic [IW-1:0]       OWNER,
  output logic                BUSY
);
  import demo_arb_pkg::*;

  localparam int unsigned   CW      = $clog2(MAX_HOLD + 1);
  localparam logic [CW-1:0] CNT_SAT = CW'(MAX_HOLD - 1);
  localparam logic [CW-1:0] CNT_MIN = CW'(MIN_HOLD - 1);
  localparam logic [IW-1:0] LAST    = IW'(N_REQ - 1);

  state_t        state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic [IW-1:0] win;
  logic          any;
  logic          own_req;
  logic          min_met;
  logic          release_now;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req (REQ),
    .ptr (ptr),
    .win (win),
    .any (any)
  );

  assign own_req = REQ[OWNER];
  assign min_met = (cnt >= CNT_MIN);

`ifdef DEMO_ARB_TIMEOUT_EN
  logic [N_REQ-1:0] other_req;

  always_comb begin
    other_req        = REQ;
    other_req[OWNER] = 1'b0;
  end

  // Pre-emption only fires once the counter has saturated and someone else is waiting.
  assign release_now = (!own_req && min_met) || ((cnt == CNT_SAT) && (|other_req));
`else
  assign release_now = !own_req && min_met;
`endif

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= IDLE;
      GNT   <= '0;
      O     <= '0;
      OWNER <= '0;
      BUSY  <= 1'b0;
      ptr   <= '0;
      cnt   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (any) begin
            state <= HOLD;
            GNT   <= N_REQ'(1) << win;
            OWNER <= win;
            BUSY  <= 1'b1;
            O     <= DATA[win*DW +: DW];
            cnt   <= '0;
          end
        end
        HOLD: begin
          if (release_now) begin
            state <= GAP;
            GNT   <= '0;
            O     <= '0;
            OWNER <= '0;
            BUSY  <= 1'b0;
            cnt   <= '0;
            ptr   <= (OWNER == LAST) ? '0 : OWNER + 1'b1;
          end else begin
            O <= DATA[OWNER*DW +: DW];
            if (cnt != CNT_SAT) cnt <= cnt + 1'b1;
          end
        end
        GAP:     state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/demo_out_arbiter_rr_pick.sv
// rr_pick: combinational round-robin picker; first set request searching upward from ptr,
// wrapping modulo N_REQ.
module rr_pick #(
  parameter  int unsigned N_REQ = demo_arb_pkg::N_REQ,
  localparam int unsigned IW    = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    win,
  output logic             any
);

  logic [IW-1:0] cand;

  always_comb begin
    win  = '0;
    any  = 1'b0;
    cand = '0;
    for (int unsigned i = 0; i < N_REQ; i++) begin
      cand = IW'((32'(ptr) + i) % N_REQ);
      if (!any && req[cand]) begin
        win = cand;
        any = 1'b1;
      end
    end
  end

endmodule

// File: rtl/demo_out_arbiter.sv
// demo_out_arbiter: round-robin owner of the demo's shared output pin group.
// Optional owner pre-emption: define DEMO_ARB_TIMEOUT_EN.
module demo_out_arbiter #(
  parameter int unsigned N_REQ    = demo_arb_pkg::N_REQ,
  parameter int unsigned DW       = demo_arb_pkg::DW,
  parameter int unsigned MIN_HOLD = demo_arb_pkg::MIN_HOLD,
  parameter int unsigned MAX_HOLD = demo_arb_pkg::MAX_HOLD
) (
  input logic               CLK,
  input logic               RST,
  demo_out_arbiter_if.slave bus
);

  demo_arb_out #(
    .N_REQ    (N_REQ),
    .DW       (DW),
    .MIN_HOLD (MIN_HOLD),
    .MAX_HOLD (MAX_HOLD)
  ) u_arb_out (
    .CLK   (CLK),
    .RST   (RST),
    .REQ   (bus.REQ),
    .DATA  (bus.DATA),
    .GNT   (bus.GNT),
    .O     (bus.O),
    .OWNER (bus.OWNER),
    .BUSY  (bus.BUSY)
  );

endmodule

// File: tb/tb_demo_out_arbiter.sv
// Directed scoreboard bench for demo_out_arbiter (N_REQ=4, DW=4, MIN_HOLD=2, MAX_HOLD=15).
// Build with DEMO_ARB_TIMEOUT_EN defined to exercise the pre-emption path.
module tb_demo_out_arbiter;

  logic CLK = 1'b0;
  logic RST;

  always #5 CLK = ~CLK;

  demo_out_arbiter_if #(.N_REQ(4), .DW(4)) bus ();

  demo_out_arbiter #(
    .N_REQ    (4),
    .DW       (4),
    .MIN_HOLD (2),
    .MAX_HOLD (15)
  ) dut (
    .CLK (CLK),
    .RST (RST),
    .bus (bus)
  );

  typedef struct {
    string      tag;
    logic [3:0] gnt;
    logic [3:0] o;
    logic [1:0] owner;
    logic       busy;
  } exp_t;

  exp_t exp_q[$];
  int   n_assert = 0;
  int   n_fail   = 0;

  localparam logic [15:0] D0 = 16'hDCBA;
  localparam logic [15:0] D1 = 16'h5678;

  function automatic logic [3:0] sl(input logic [15:0] d, input int i);
    return d[i*4 +: 4];
  endfunction

  // Drive one cycle of inputs and queue the outputs expected after the next edge.
  task automatic step(input string tag, input logic rst, input logic [3:0] req,
                      input logic [15:0] data, input logic [3:0] gnt, input logic [3:0] o,
                      input logic [1:0] owner, input logic busy);
    exp_t e;
    @(negedge CLK);
    RST      = rst;
    bus.REQ  = req;
    bus.DATA = data;
    e.tag    = tag;
    e.gnt    = gnt;
    e.o      = o;
    e.owner  = owner;
    e.busy   = busy;
    exp_q.push_back(e);
  endtask

  initial begin
    exp_t e;
    forever begin
      @(posedge CLK);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_assert++;
        if (bus.GNT !== e.gnt || bus.O !== e.o || bus.OWNER !== e.owner || bus.BUSY !== e.busy) begin
          n_fail++;
          $display("FAIL %s: got gnt=%b o=%h owner=%0d busy=%b, expected gnt=%b o=%h owner=%0d busy=%b",
                   e.tag, bus.GNT, bus.O, bus.OWNER, bus.BUSY, e.gnt, e.o, e.owner, e.busy);
        end
      end
    end
  end

  initial begin
    int w;
    RST      = 1'b1;
    bus.REQ  = '0;
    bus.DATA = '0;

    step("reset_a", 1'b1, 4'b1111, D0, '0, '0, '0, 1'b0);
    step("reset_b", 1'b1, 4'b1111, D0, '0, '0, '0, 1'b0);

    // All four requesting: each owner drops its bit once to hand over, order 0,1,2,3,0.
    for (int k = 0; k < 5; k++) begin
      w = k % 4;
      step($sformatf("rr_grant%0d", k), 1'b0, 4'b1111, D0, 4'(1 << w), sl(D0, w), 2'(w), 1'b1);
      step($sformatf("rr_live%0d", k), 1'b0, 4'b1111, D1, 4'(1 << w), sl(D1, w), 2'(w), 1'b1);
      step($sformatf("rr_release%0d", k), 1'b0, 4'b1111 & ~(4'(1 << w)), D0, '0, '0, '0, 1'b0);
      step($sformatf("rr_gap%0d", k), 1'b0, 4'b1111, D0, '0, '0, '0, 1'b0);
    end

    // Early drop is held off until the minimum hold is met.
    step("min_grant",   1'b0, 4'b0010, 16'h00A0, 4'b0010, 4'hA, 2'd1, 1'b1);
    step("min_ignore",  1'b0, 4'b0000, 16'h00B0, 4'b0010, 4'hB, 2'd1, 1'b1);
    step("min_release", 1'b0, 4'b0000, 16'h00B0, '0, '0, '0, 1'b0);
    step("min_gap",     1'b0, 4'b0000, 16'h00B0, '0, '0, '0, 1'b0);
    step("min_idle",    1'b0, 4'b0000, 16'h00B0, '0, '0, '0, 1'b0);

    // Owner 3 releases; pointer wraps to 0 so requester 0 wins over 3.
    step("wrap_grant3",  1'b0, 4'b1000, D0, 4'b1000, 4'hD, 2'd3, 1'b1);
    step("wrap_hold_a",  1'b0, 4'b1001, D0, 4'b1000, 4'hD, 2'd3, 1'b1);
    step("wrap_hold_b",  1'b0, 4'b1001, D0, 4'b1000, 4'hD, 2'd3, 1'b1);
    step("wrap_release", 1'b0, 4'b0001, D0, '0, '0, '0, 1'b0);
    step("wrap_gap",     1'b0, 4'b1001, D0, '0, '0, '0, 1'b0);
    step("wrap_to0",     1'b0, 4'b1001, D0, 4'b0001, 4'hA, 2'd0, 1'b1);

`ifdef DEMO_ARB_TIMEOUT_EN
    for (int i = 0; i < 14; i++)
      step($sformatf("to_hold%0d", i), 1'b0, 4'b0011, D0, 4'b0001, 4'hA, 2'd0, 1'b1);
    step("to_preempt", 1'b0, 4'b0011, D0, '0, '0, '0, 1'b0);
    step("to_gap",     1'b0, 4'b0011, D0, '0, '0, '0, 1'b0);
`else
    for (int i = 0; i < 20; i++)
      step($sformatf("no_preempt%0d", i), 1'b0, 4'b0011, D0, 4'b0001, 4'hA, 2'd0, 1'b1);
    step("drop_release", 1'b0, 4'b0010, D0, '0, '0, '0, 1'b0);
    step("drop_gap",     1'b0, 4'b0010, D0, '0, '0, '0, 1'b0);
`endif
    step("next_grant1", 1'b0, 4'b0010, D0, 4'b0010, 4'hB, 2'd1, 1'b1);

    step("own1_hold",    1'b0, 4'b0100, D0, 4'b0010, 4'hB, 2'd1, 1'b1);
    step("own1_release", 1'b0, 4'b0100, D0, '0, '0, '0, 1'b0);
    step("own1_gap",     1'b0, 4'b0100, D0, '0, '0, '0, 1'b0);
    step("grant2",       1'b0, 4'b0100, D0, 4'b0100, 4'hC, 2'd2, 1'b1);
    step("hold2",        1'b0, 4'b0100, D0, 4'b0100, 4'hC, 2'd2, 1'b1);

    // Reset mid-HOLD clears outputs and the pointer: 0 beats 2 afterwards.
    step("rst_mid",  1'b1, 4'b0101, D0, '0, '0, '0, 1'b0);
    step("post_rst", 1'b0, 4'b0101, D0, 4'b0001, 4'hA, 2'd0, 1'b1);

    for (int i = 0; i < 20; i++)
      step($sformatf("solo_hold%0d", i), 1'b0, 4'b0001, D0, 4'b0001, 4'hA, 2'd0, 1'b1);
    step("solo_release", 1'b0, 4'b0000, D0, '0, '0, '0, 1'b0);
    step("solo_gap",     1'b0, 4'b0000, D0, '0, '0, '0, 1'b0);
    step("solo_idle",    1'b0, 4'b0000, D0, '0, '0, '0, 1'b0);

    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge CLK);
    #2;
    if (exp_q.size() != 0) begin
      n_assert++;
      n_fail++;
      $display("FAIL drain: %0d expectations left, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
